// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS/CTRL bit layout and default sizing.
package dmem_mmio_responder_pkg;

  localparam int unsigned DEFAULT_RAM_WORDS  = 64;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

  // Byte offsets from the MMIO window base.
  localparam logic [31:0] MMIO_TX_OFF     = 32'h0000_0000;
  localparam logic [31:0] MMIO_STATUS_OFF = 32'h0000_0004;
  localparam logic [31:0] MMIO_CTRL_OFF   = 32'h0000_0008;

  localparam int STATUS_OVF_BIT   = 31;
  localparam int STATUS_FULL_BIT  = 15;
  localparam int STATUS_EMPTY_BIT = 14;
  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 8;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_TX,
    REGION_STATUS,
    REGION_CTRL
  } region_e;

  function automatic logic [31:0] pack_status(input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                                         = '0;
    s[STATUS_OVF_BIT]                         = ovf;
    s[STATUS_FULL_BIT]                        = full;
    s[STATUS_EMPTY_BIT]                       = empty;
    s[STATUS_COUNT_LSB +: STATUS_COUNT_W]     = count;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: dout always shows the head entry,
// a push is only visible after the edge that stores it.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_push,  do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM with combinational reads plus an MMIO window
// whose TX register feeds a FWFT FIFO drained over a valid/ready stream.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = DEFAULT_RAM_WORDS,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic        write_enable,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [29:0]       word_addr;
  logic [31:0]       aligned_addr;
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;

  logic              ram_wr, tx_wr, ctrl_wr;
  logic              fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status_word;
  logic              overflow_q, overflow_d;
  logic              unused_addr_bits;

  assign word_addr        = address_to_mem[31:2];
  assign aligned_addr     = {word_addr, 2'b00};
  assign ram_idx          = word_addr[RAM_AW-1:0];
  assign unused_addr_bits = ^address_to_mem[1:0];

  always_comb begin
    region = REGION_NONE;
    if (word_addr < 30'(RAM_WORDS))                      region = REGION_RAM;
    else if (aligned_addr == MMIO_BASE + MMIO_TX_OFF)     region = REGION_TX;
    else if (aligned_addr == MMIO_BASE + MMIO_STATUS_OFF) region = REGION_STATUS;
    else if (aligned_addr == MMIO_BASE + MMIO_CTRL_OFF)   region = REGION_CTRL;
  end

  assign ram_wr     = write_enable && (region == REGION_RAM);
  assign tx_wr      = write_enable && (region == REGION_TX);
  assign ctrl_wr    = write_enable && (region == REGION_CTRL);
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_flush = ctrl_wr && data_to_mem[CTRL_FLUSH];

  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; its contents must survive reset and a reset would block RAM inference.
    if (ram_wr) ram_q[ram_idx] <= data_to_mem;
  end

  sync_fifo_fwft #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (data_to_mem),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  // A push into a full FIFO is dropped unless the head pops in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (ctrl_wr && data_to_mem[CTRL_CLR_OVF])   overflow_d = 1'b0;
    if (tx_wr && fifo_full && !fifo_pop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow    = overflow_q;
  assign status_word = pack_status(overflow_q, fifo_full, fifo_empty, 8'(fifo_count));

  always_comb begin
    data_from_mem = '0;
    unique case (region)
      REGION_RAM:    data_from_mem = ram_q[ram_idx];
      REGION_STATUS: data_from_mem = status_word;
      default:       data_from_mem = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_dmem_mmio_responder;

  logic        clk;
  logic        reset;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic        write_enable;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 64-word RAM with known-word tracking, TX queue, sticky flag.
  logic [31:0] m_ram   [64];
  bit          m_known [64];
  logic [31:0] m_q [$];
  bit          m_ovf;

  dmem_mmio_responder dut (
    .clk            (clk),
    .reset          (reset),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .write_enable   (write_enable),
    .data_from_mem  (data_from_mem),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_q.size());
    if (m_ovf)             s = s + 32'h8000_0000;
    if (m_q.size() == 8)   s = s + 32'h0000_8000;
    if (m_q.size() == 0)   s = s + 32'h0000_4000;
    return s;
  endfunction

  function automatic bit m_readable(input logic [31:0] addr);
    int a = int'(addr >> 2);
    if (addr < 32'h100) return m_known[a];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    if (addr < 32'h100)                 return m_ram[int'(addr >> 2)];
    if ((addr & ~32'h3) == 32'h404)     return m_status();
    return 32'h0;
  endfunction

  task automatic model_edge(input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic rdy);
    logic [31:0] aligned = addr & ~32'h3;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (we) begin
      if (addr < 32'h100) begin
        m_ram[int'(addr >> 2)]   = data;
        m_known[int'(addr >> 2)] = 1'b1;
      end else if (aligned == 32'h400) begin
        if (m_q.size() < 8) m_q.push_back(data);
        else                m_ovf = 1'b1;
      end else if (aligned == 32'h408) begin
        if (data[0]) m_ovf = 1'b0;
        if (data[1]) m_q.delete();
      end
    end
  endtask

  task automatic check_state(input string where);
    check({where, "_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check({where, "_data"}, out_data, m_q[0]);
    check({where, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_readable(address_to_mem)) check({where, "_rd"}, data_from_mem, m_read(address_to_mem));
  endtask

  // Called at posedge+1: drive, check pre-edge view, clock, update model, check.
  task automatic step(input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy);
    write_enable   = we;
    address_to_mem = addr;
    data_to_mem    = data;
    out_ready      = rdy;
    #2;
    check_state("pre");
    @(posedge clk);
    model_edge(we, addr, data, rdy);
    #1;
    check_state("post");
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 32'h400, base + 32'(i), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h404, 32'h0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must fall without a clock.
  task automatic async_reset_mid();
    write_enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_ovf",   32'(overflow),  32'h0);
    m_q.delete();
    m_ovf = 1'b0;
    check_state("arst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] last_word;
    int          guard;
    logic [31:0] other_addrs [5];
    other_addrs[0] = 32'h0000_0100;
    other_addrs[1] = 32'h0000_0300;
    other_addrs[2] = 32'h0000_040C;
    other_addrs[3] = 32'hFFFF_FFFC;
    other_addrs[4] = 32'h0000_0500;

    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    m_ovf          = 1'b0;
    reset          = 1'b0;
    write_enable   = 1'b0;
    address_to_mem = 32'h300;
    data_to_mem    = 32'h0;
    out_ready      = 1'b0;

    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_rd",    data_from_mem,  32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // RAM write/read, byte-offset aliasing, unmapped read
    step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0);
    check("ram_rd", data_from_mem, 32'hDEADBEEF);
    step(1'b0, 32'h13, 32'h0, 1'b0);
    check("ram_rd_off", data_from_mem, 32'hDEADBEEF);
    step(1'b0, 32'h300, 32'h0, 1'b0);
    check("unmapped_rd", data_from_mem, 32'h0);
    step(1'b1, 32'hFC, 32'h1234_5678, 1'b0);
    step(1'b0, 32'h100, 32'h0, 1'b0);
    check("ram_edge_rd", data_from_mem, 32'h0);

    // Single TX word
    step(1'b1, 32'h400, 32'h41, 1'b0);
    check("tx_valid", 32'(out_valid), 32'h1);
    check("tx_data",  out_data, 32'h41);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("status_one", data_from_mem, 32'h0000_0001);
    step(1'b0, 32'h404, 32'h0, 1'b1);
    check("tx_popped", 32'(out_valid), 32'h0);
    check("status_empty", data_from_mem, 32'h0000_4000);

    // Fill, overflow, ordered drain
    fill(8, 32'h1);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("status_full", data_from_mem, 32'h0000_8008);
    step(1'b1, 32'h400, 32'h9, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("status_ovf", data_from_mem, 32'h8000_8008);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", out_data, 32'(i));
      step(1'b0, 32'h404, 32'h0, 1'b1);
    end
    check("drain_done", 32'(out_valid), 32'h0);

    // Simultaneous push and pop while full
    step(1'b1, 32'h408, 32'h1, 1'b0);
    fill(8, 32'h10);
    step(1'b1, 32'h400, 32'hAA, 1'b1);
    check("pushpop_ovf", 32'(overflow), 32'h0);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("pushpop_status", data_from_mem, 32'h0000_8008);
    last_word = 32'h0;
    guard     = 0;
    while (out_valid && guard < 20) begin
      last_word = out_data;
      step(1'b0, 32'h404, 32'h0, 1'b1);
      guard++;
    end
    check("drain_bounded", 32'(guard < 20), 32'h1);
    check("drain_last", last_word, 32'hAA);

    // CTRL clear-overflow and flush
    fill(8, 32'h100);
    step(1'b1, 32'h400, 32'hBAD, 1'b0);
    drain(5);
    step(1'b1, 32'h408, 32'h1, 1'b0);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("ctrl_clr", data_from_mem, 32'h0000_0003);
    step(1'b1, 32'h408, 32'h2, 1'b1);
    check("ctrl_flush", 32'(out_valid), 32'h0);
    step(1'b0, 32'h404, 32'h0, 1'b0);
    check("ctrl_status", data_from_mem, 32'h0000_4000);

    // Async reset mid-drain
    fill(8, 32'h200);
    step(1'b1, 32'h400, 32'hBAD, 1'b0);
    drain(3);
    address_to_mem = 32'h10;
    out_ready      = 1'b1;
    async_reset_mid();
    step(1'b0, 32'h10, 32'h0, 1'b0);
    check("ram_after_rst", data_from_mem, 32'hDEADBEEF);

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      int          r;
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      r    = int'($urandom_range(0, 99));
      data = $urandom;
      we   = 1'($urandom_range(0, 1));
      if (r < 35)      addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 65) addr = 32'h400;
      else if (r < 80) addr = 32'h404;
      else if (r < 84) begin
        addr = 32'h408;
        data = 32'($urandom_range(0, 3));
      end else         addr = other_addrs[$urandom_range(0, 4)];
      if ($urandom_range(0, 199) == 0) begin
        address_to_mem = addr;
        out_ready      = 1'b1;
        async_reset_mid();
      end else begin
        step(we, addr, data, 1'($urandom_range(0, 9) < 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Memory-side responder for the core's data-memory write/read interface. It consumes `address_to_mem`, `data_to_mem` and `write_enable`, and returns `data_from_mem`. It serves a word-addressed RAM plus a small MMIO window. Stores to the MMIO TX register are buffered in a FIFO and drained over a valid/ready stream, giving the system a store-trace/console output alongside the RAM.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; byte addresses 0 .. 4*RAM_WORDS-1
FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
MMIO_BASE, 32'h0000_0400, byte address of the MMIO window; must lie above the RAM range

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
address_to_mem  in  32  byte address from core; bits [1:0] ignored
data_to_mem  in  32  store data from core
write_enable  in  1  store strobe, sampled at rising clk
data_from_mem  out  32  combinational read data for address_to_mem
out_data  out  32  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts out_data this cycle
overflow  out  1  sticky: a TX push was dropped

Behaviour:
- Address decode, using word address `A = address_to_mem[31:2]`:
  - RAM: `A < RAM_WORDS`.
  - TX: byte address `MMIO_BASE+0`, write-only; reads return 0.
  - STATUS: `MMIO_BASE+4`, read-only.
  - CTRL: `MMIO_BASE+8`, write-only.
  - Any other address: writes ignored, reads return 0.
- RAM:
  - Read is combinational, with no read latency.
  - Write occurs at rising clk when `write_enable` is high.
  - Read-during-write at the same address returns the old word until the edge.
  - RAM contents are not affected by reset.
- TX push:
  - Condition: `write_enable` high and address == TX.
  - On a successful push, `data_to_mem` is stored at the tail at the edge.
  - `out_valid` rises in the cycle after the first push into an empty FIFO (1-cycle latency).
- Pop:
  - Condition: `out_valid && out_ready` at the rising edge; the head advances.
  - `out_data` is first-word-fall-through: it always shows the current head and is stable while `out_valid && !out_ready`.
  - When empty, `out_data` is don't-care; the bench must not check it.
- Occupancy counter:
  - Width `clog2(FIFO_DEPTH)+1`, range 0..FIFO_DEPTH.
  - Push-only increments; pop-only decrements; push+pop in the same cycle leaves it unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Full FIFO:
  - Push without pop: the data is dropped and `overflow` is set at that edge.
  - Push with simultaneous pop: both succeed, no overflow, count stays FIFO_DEPTH.
- Empty FIFO: `out_valid` = 0, so no pop can occur. A push in this state makes the word visible in the next cycle (no same-cycle bypass).
- STATUS read value: `{overflow, 15'b0, full, empty, 6'b0, count (zero-extended to 8 bits)}`, laid out at bit 31, bits 30:16, bit 15, bit 14, bits 13:8 and bits 7:0 respectively. It reflects register state before the current edge.
- CTRL write: `data_to_mem[0]==1` clears `overflow`; `data_to_mem[1]==1` flushes the FIFO (pointers and count set to 0). Only one store occurs per cycle, so CTRL and TX accesses never coincide.
- If a flush and a pop occur in the same cycle, the flush wins.
- Reset (`reset==0`, asynchronous, effective at any time including mid-drain):
  - Pointers and count = 0, so `out_valid` = 0.
  - `overflow` = 0.
  - `data_from_mem` follows decode (RAM unaffected).
  - Pushes or pops in flight at assertion are lost.
  - Outputs are valid with reset values immediately on assertion, without waiting for clk.

Decomposition:
- Shared package holds:
  - MMIO offset constants (TX=0, STATUS=4, CTRL=8).
  - STATUS bit-position constants.
  - CTRL bit constants (CLR_OVF=0, FLUSH=1).
  - Default RAM_WORDS / FIFO_DEPTH.
- One sub-module, `sync_fifo_fwft`:
  - Parameterised width/depth.
  - Ports: push, pop, flush, din, dout, count, full, empty; same clk and active-low async reset.
- The top level holds the RAM array, address decode, the overflow flag and the read mux.

Test Plan:
- Reset then RAM access: hold reset low 2 cycles, release. Store 32'hDEADBEEF at 0x10, then read 0x10 → `data_from_mem` = DEADBEEF. Read 0x13 → same word. Read 0x300 → 0.
- Single TX: store 32'h41 to 0x400 with `out_ready`=0 → next cycle `out_valid`=1, `out_data`=41, and STATUS read = 32'h0000_0001. Raise `out_ready` for 1 cycle → `out_valid`=0, STATUS = 32'h0000_4000.
- Fill and overflow: push 1..8 to TX with `out_ready`=0 → STATUS = 32'h0000_8008. Push 9 → `overflow`=1, STATUS = 32'h8000_8008. Drain → words 1..8 emerge in order; 9 is never seen.
- Simultaneous push/pop at full: with 8 entries and `out_ready`=1, push 32'hAA → `overflow` stays 0, count stays 8. The drain sequence ends with AA.
- CTRL: with `overflow`=1 and 3 entries, store 32'h1 to 0x408 → `overflow`=0, count 3. Store 32'h2 → `out_valid`=0 next cycle, count 0.
- Async reset mid-drain: with 5 entries and `out_ready`=1, assert reset between edges → `out_valid` and `overflow` drop immediately. After release, a previously stored RAM word at 0x10 still reads DEADBEEF.
